chan_scan_mux_par: RTL and testbench



---
 rtl/chan_scan_mux_par.sv | 142 ++++++++++++++
 tb/tb_chan_scan_mux_par.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/chan_scan_mux_par.sv
// Channel selector with a fixed-index mode and an ascending one-pass sweep over enabled channels.
// The selected word is registered together with its parity and offered on a valid/ready output.
module chan_scan_mux_par #(
  parameter int WIDTH   = 8,
  parameter int NCH     = 4,
  parameter int SELW    = 2,
  parameter int PAR_ODD = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel_in,
  input  logic [NCH-1:0]         ch_en,
  input  logic [NCH*WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_ch,
  output logic                   out_par,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [NCH-1:0]    mask_q, mask_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic              par_q, par_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  selWord;
  logic [SELW-1:0]   firstEn;
  logic [SELW-1:0]   nextPtr;
  logic              nextFound;
  logic              ptrErr;

  // Index-compare mux, so a non-power-of-two NCH simply yields zero for unused indices.
  always_comb begin
    selWord   = '0;
    firstEn   = '0;
    nextPtr   = '0;
    nextFound = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (ptr_q == SELW'(k)) selWord = data_in[k*WIDTH +: WIDTH];
      if (ch_en[k]) firstEn = SELW'(k);
      if (mask_q[k] && (k > int'(ptr_q))) begin
        nextPtr   = SELW'(k);
        nextFound = 1'b1;
      end
    end
    ptrErr = !mode_q && (int'(ptr_q) >= NCH);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    ch_d    = ch_q;
    par_d   = par_q;
    err_d   = err_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start && !mode) begin
          mode_d  = 1'b0;
          ptr_d   = sel_in;
          mask_d  = '0;
          state_d = LOAD;
        end else if (start && mode && (ch_en != '0)) begin
          mode_d  = 1'b1;
          ptr_d   = firstEn;
          mask_d  = ch_en;
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d  = ptrErr ? '0 : selWord;
        ch_d    = ptr_q;
        err_d   = ptrErr;
        par_d   = (^data_d) ^ (PAR_ODD != 0);
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (mode_q && nextFound) begin
            ptr_d   = nextPtr;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      ptr_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      par_q   <= par_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_par   = par_q;
  assign out_err   = err_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_chan_scan_mux_par.sv
// Directed scoreboard bench for chan_scan_mux_par: three instances cover NCH=4 even parity,
// NCH=3 even parity and NCH=3 odd parity, sharing the control inputs.
module tb_chan_scan_mux_par;

  logic        clk = 1'b0;
  logic        rst_n, start, mode, outReady;
  logic [1:0]  selIn;
  logic [3:0]  chEnA;
  logic [2:0]  chEnS;
  logic [31:0] dataA;
  logic [23:0] dataB, dataC;

  logic [7:0]  aData, bData, cData;
  logic [1:0]  aCh, bCh, cCh;
  logic        aPar, bPar, cPar, aErr, bErr, cErr;
  logic        aValid, bValid, cValid, aBusy, bBusy, cBusy;

  logic [7:0]  obsData;
  logic [1:0]  obsCh;
  logic        obsPar, obsErr, obsValid, obsBusy;

  int compared   = 0;
  int mismatched = 0;
  int which      = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
    logic       par;
    logic       err;
  } word_t;

  word_t sb[$];

  always #5 clk = ~clk;

  chan_scan_mux_par #(.WIDTH(8), .NCH(4), .SELW(2), .PAR_ODD(0)) dutA (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .sel_in(selIn),
    .ch_en(chEnA), .data_in(dataA), .out_data(aData), .out_ch(aCh), .out_par(aPar),
    .out_err(aErr), .out_valid(aValid), .out_ready(outReady), .busy(aBusy)
  );

  chan_scan_mux_par #(.WIDTH(8), .NCH(3), .SELW(2), .PAR_ODD(0)) dutB (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .sel_in(selIn),
    .ch_en(chEnS), .data_in(dataB), .out_data(bData), .out_ch(bCh), .out_par(bPar),
    .out_err(bErr), .out_valid(bValid), .out_ready(outReady), .busy(bBusy)
  );

  chan_scan_mux_par #(.WIDTH(8), .NCH(3), .SELW(2), .PAR_ODD(1)) dutC (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .sel_in(selIn),
    .ch_en(chEnS), .data_in(dataC), .out_data(cData), .out_ch(cCh), .out_par(cPar),
    .out_err(cErr), .out_valid(cValid), .out_ready(outReady), .busy(cBusy)
  );

  // Route the instance currently under test onto one set of observation signals.
  always_comb begin
    obsData  = aData;
    obsCh    = aCh;
    obsPar   = aPar;
    obsErr   = aErr;
    obsValid = aValid;
    obsBusy  = aBusy;
    if (which == 1) begin
      obsData = bData; obsCh = bCh; obsPar = bPar; obsErr = bErr; obsValid = bValid; obsBusy = bBusy;
    end else if (which == 2) begin
      obsData = cData; obsCh = cCh; obsPar = cPar; obsErr = cErr; obsValid = cValid; obsBusy = cBusy;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0; start = 1'b0; outReady = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Start is sampled on the edge inside this task; latched fields are scrambled afterwards.
  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] ea, input logic [2:0] es);
    @(negedge clk);
    start = 1'b1; mode = m; selIn = s; chEnA = ea; chEnS = es;
    @(negedge clk);
    start = 1'b0; mode = ~m; selIn = ~s; chEnA = 4'hF; chEnS = 3'h7;
  endtask

  // Pops the expected word, waits (bounded) for it, checks it through a backpressure window, then accepts it.
  task automatic getWord(input string tag, input int maxWait, input int holdCycles,
                         input bit pulseStart, input bit changeData);
    word_t e;
    int waited = 0;
    e = sb.pop_front();
    while (!obsValid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_valid"}, 32'(obsValid && (waited <= maxWait)), 32'(1));
    if (!obsValid) return;
    checkOutput({tag, "_data"}, 32'(obsData), 32'(e.data));
    checkOutput({tag, "_ch"},   32'(obsCh),   32'(e.ch));
    checkOutput({tag, "_par"},  32'(obsPar),  32'(e.par));
    checkOutput({tag, "_err"},  32'(obsErr),  32'(e.err));
    for (int i = 0; i < holdCycles; i++) begin
      if (i == 0 && pulseStart) begin start = 1'b1; mode = 1'b0; selIn = 2'd0; end
      if (i == 0 && changeData) begin dataA = '1; dataB = '1; dataC = '1; end
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, "_holdData"},  32'(obsData),  32'(e.data));
      checkOutput({tag, "_holdCh"},    32'(obsCh),    32'(e.ch));
      checkOutput({tag, "_holdValid"}, 32'(obsValid), 32'(1));
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; outReady = 1'b0; selIn = '0;
    chEnA = '0; chEnS = '0; dataA = '0; dataB = '0; dataC = '0;
    #12;
    checkOutput("rst_valid", 32'(aValid), 32'(0));
    checkOutput("rst_busy",  32'(aBusy),  32'(0));
    checkOutput("rst_data",  32'(aData),  32'(0));
    checkOutput("rst_errpar", 32'({aErr, aPar, aCh}), 32'(0));
    doReset();
    checkOutput("idle_busy", 32'(aBusy), 32'(0));

    $display("[TB] fixed channel, even parity");
    which = 0;
    dataA = {8'h11, 8'hA7, 8'h22, 8'h33};
    sb.push_back('{data: 8'hA7, ch: 2'd2, par: 1'b1, err: 1'b0});
    applyStimulus(1'b0, 2'd2, 4'h0, 3'h0);
    checkOutput("fix_busyEarly",  32'(aBusy),  32'(1));
    checkOutput("fix_validEarly", 32'(aValid), 32'(0));
    @(negedge clk);
    getWord("fix", 0, 0, 1'b0, 1'b0);
    checkOutput("fix_busyAfter",  32'(aBusy),  32'(0));
    checkOutput("fix_validAfter", 32'(aValid), 32'(0));

    $display("[TB] sweep with backpressure");
    doReset();
    dataA = {8'hFF, 8'h55, 8'h03, 8'h01};
    sb.push_back('{data: 8'h01, ch: 2'd0, par: 1'b1, err: 1'b0});
    sb.push_back('{data: 8'h03, ch: 2'd1, par: 1'b0, err: 1'b0});
    sb.push_back('{data: 8'hFF, ch: 2'd3, par: 1'b0, err: 1'b0});
    applyStimulus(1'b1, 2'd0, 4'b1011, 3'h0);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      getWord("sweep", 0, 3, 1'b0, 1'b0);
      checkOutput("sweep_bubble", 32'(aValid), 32'(0));
      if (w < 2) @(negedge clk);
    end
    checkOutput("sweep_idle", 32'(aBusy), 32'(0));
    repeat (3) @(negedge clk);
    checkOutput("sweep_noExtra", 32'(aValid), 32'(0));

    $display("[TB] out-of-range index");
    doReset();
    which = 1;
    dataB = 24'h123456;
    sb.push_back('{data: 8'h00, ch: 2'd3, par: 1'b0, err: 1'b1});
    applyStimulus(1'b0, 2'd3, 4'h0, 3'h0);
    getWord("oorEven", 1, 0, 1'b0, 1'b0);
    doReset();
    which = 2;
    dataC = 24'h123456;
    sb.push_back('{data: 8'h00, ch: 2'd3, par: 1'b1, err: 1'b1});
    applyStimulus(1'b0, 2'd3, 4'h0, 3'h0);
    getWord("oorOdd", 1, 0, 1'b0, 1'b0);

    $display("[TB] empty mask and ignored start");
    doReset();
    which = 0;
    applyStimulus(1'b1, 2'd0, 4'h0, 3'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("empty_busy",  32'(aBusy),  32'(0));
      checkOutput("empty_valid", 32'(aValid), 32'(0));
      @(negedge clk);
    end
    dataA = {8'hFF, 8'h55, 8'h03, 8'h01};
    sb.push_back('{data: 8'h03, ch: 2'd1, par: 1'b0, err: 1'b0});
    sb.push_back('{data: 8'hFF, ch: 2'd3, par: 1'b0, err: 1'b0});
    applyStimulus(1'b1, 2'd0, 4'b1010, 3'h0);
    getWord("ign1", 1, 2, 1'b1, 1'b0);
    getWord("ign3", 1, 0, 1'b0, 1'b0);
    checkOutput("ign_idle", 32'(aBusy), 32'(0));

    $display("[TB] odd parity and data change in HOLD");
    doReset();
    which = 2;
    dataC = {8'h5A, 8'h00, 8'h77};
    sb.push_back('{data: 8'h00, ch: 2'd1, par: 1'b1, err: 1'b0});
    applyStimulus(1'b0, 2'd1, 4'h0, 3'h0);
    getWord("odd", 1, 3, 1'b0, 1'b1);

    $display("[TB] asynchronous reset mid-HOLD");
    doReset();
    which = 0;
    dataA = {8'h11, 8'hA7, 8'h22, 8'h33};
    applyStimulus(1'b0, 2'd2, 4'h0, 3'h0);
    @(negedge clk);
    checkOutput("arst_preValid", 32'(aValid), 32'(1));
    checkOutput("arst_preData",  32'(aData),  32'(8'hA7));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(aValid), 32'(0));
    checkOutput("arst_data",  32'(aData),  32'(0));
    checkOutput("arst_busy",  32'(aBusy),  32'(0));
    checkOutput("arst_chpar", 32'({aCh, aPar, aErr}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("arst_idleBusy",  32'(aBusy),  32'(0));
    checkOutput("arst_idleValid", 32'(aValid), 32'(0));

    checkOutput("sb_empty", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
